alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Initiator side of the ALU interface: accepts 32-bit RV32I ALU instructions over a
//  valid/ready handshake, decodes them, and reads operands from an internal 32-entry
//  register file. It drives opcode/func3/func7_5/operands to the combinational alu and
//  writes alu_result back. It sits between instruction fetch and the alu.
// PARAMETERS
//  DW  32  data width of registers, operands and result (>=8)
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   synchronous reset, active-high
//  instr_valid_i    in   1   instruction offered
//  instr_ready_o    out  1   unit can accept instruction
//  instr_i          in   32  RV32I instruction word
//  opcode_o         out  7   to alu opcode
//  func3_o          out  3   to alu func3
//  func7_5_o        out  1   to alu func7_5
//  alu_operand_1_o  out  DW  to alu operand 1
//  alu_operand_2_o  out  DW  to alu operand 2
//  alu_result_i     in   DW  from alu result
//  rd_we_o          out  1   1-cycle pulse: register write performed
//  rd_addr_o        out  5   destination register of the write
//  rd_data_o        out  DW  data written
//  done_o           out  1   1-cycle pulse: instruction retired (legal or not)
//  illegal_o        out  1   1-cycle pulse with done_o: unsupported opcode
//  dbg_addr_i       in   5   debug read address
//  dbg_data_o       out  DW  combinational read of regfile[dbg_addr_i]; x0 reads 0
// BEHAVIOUR
//  - Reset: state IDLE; all regfile entries 0. instr_ready_o=1 after reset; all other
//    outputs 0. Reset in any state aborts the instruction; no write, no done_o.
//  - FSM IDLE -> EXEC -> WB -> IDLE; a new instruction starts every 3 cycles.
//    IDLE: instr_ready_o=1. On instr_valid_i&&instr_ready_o, register instr_i, go EXEC.
//          Without valid, stay IDLE.
//    EXEC: instr_ready_o=0. ALU outputs are driven from the instr register and regfile.
//          alu_result_i and legality are registered. Go WB.
//    WB:   done_o=1. If legal and rd!=0: write regfile[rd], rd_we_o=1. rd_addr_o and
//          rd_data_o hold the registered values. Go IDLE.
//  - Latency: handshake at edge N -> done_o/rd_we_o high in cycle after edge N+2.
//  - Outside EXEC, alu outputs hold 0. rd_addr_o/rd_data_o are 0 unless rd_we_o=1.
//  - Opcode 7'd51 (R-type): opcode_o=51, func3_o=instr[14:12], func7_5_o=instr[30].
//    op1=rf[rs1], op2=rf[rs2].
//  - Opcode 7'd19 (I-type, only when the macro is defined): opcode_o=51 always, since
//    the alu decodes R-type only. func3_o=instr[14:12]. op1=rf[rs1].
//    For func3 001/101, op2={0,instr[24:20]} and func7_5_o=instr[30] only for 101.
//    For all other func3, op2=sign-extended instr[31:20] and func7_5_o=0, so addi never
//    subtracts.
//  - Any other opcode is illegal: illegal_o=1 with done_o, no write. In EXEC, opcode_o,
//    func3_o, func7_5_o and both operands are 0 for an illegal opcode.
//  - x0 is hardwired to 0 for reads, and writes to it are discarded (done_o still pulses).
//  - Back-to-back dependency: a WB write is visible to the next instruction's EXEC, which
//    is at least 2 cycles later; no bypass is needed.
//  - A debug read of a register being written in WB returns the old value; the new value
//    is returned from the next cycle.
//  - instr_i is sampled only at the handshake; changes while busy are ignored.
// CONFIGURATION
//  ALU_ISSUE_IMM_EN defined: I-type opcode 19 is decoded as described above.
//  Not defined: opcode 19 is illegal (illegal_o=1, no write); R-type is unchanged.
// TESTING
//  1 Reset, then read all 32 debug addresses -> all 0; instr_ready_o=1; other outputs 0.
//  2 Preload x1=5, x2=3. add x3,x1,x2 -> EXEC opcode_o=51,func3_o=0,func7_5_o=0.
//    2 cycles after accept: rd_we_o=1, rd_addr_o=3, rd_data_o=8.
//    sub x4,x1,x2 -> x4=2. sra x5 with x1=0x80000000, x2=4 -> 0xF8000000.
//  3 add x0,x1,x2 -> done_o=1, rd_we_o=0, x0 still 0.
//    Opcode 7'h03 -> done_o=1, illegal_o=1, no regfile change.
//  4 Hold instr_valid_i=1 for 10 cycles -> exactly one accept per 3 cycles.
//    Each instruction sees the result of the previous one (x1=x1+x1 chain: 5,10,20).
//  5 Assert rst in EXEC -> no rd_we_o/done_o follows; regfile cleared; IDLE next cycle.
//  6 With ALU_ISSUE_IMM_EN: addi x6,x0,-1 -> x6=0xFFFFFFFF; srai x7,x6,4 -> func7_5_o=1,
//    x7=0xFFFFFFFF. Without ALU_ISSUE_IMM_EN: addi -> illegal_o=1, x6 stays 0.

Source files
------------

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: accepts RV32I ALU instructions, reads operands from a 32-entry
// register file, drives an external combinational ALU and writes its result back.
// Optional feature macro: ALU_ISSUE_IMM_EN (decode I-type opcode 19).
`timescale 1ns/1ps
module alu_issue_unit #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic [31:0]   instr_i,
  output logic [6:0]    opcode_o,
  output logic [2:0]    func3_o,
  output logic          func7_5_o,
  output logic [DW-1:0] alu_operand_1_o,
  output logic [DW-1:0] alu_operand_2_o,
  input  logic [DW-1:0] alu_result_i,
  output logic          rd_we_o,
  output logic [4:0]    rd_addr_o,
  output logic [DW-1:0] rd_data_o,
  output logic          done_o,
  output logic          illegal_o,
  input  logic [4:0]    dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int unsigned NREGS = 32;
  localparam logic [6:0]  OP_R  = 7'd51;
`ifdef ALU_ISSUE_IMM_EN
  localparam logic [6:0]  OP_I  = 7'd19;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] result_q, result_d;
  logic          legal_q, legal_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic          rd_we_q, rd_we_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] rf_q [NREGS];

  logic [4:0]    rs1, rs2, rd;
  logic [2:0]    f3;
  logic [DW-1:0] rs1_val, rs2_val;
  logic          dec_legal;
  logic          wb_we;
  logic          unused_instr_bits;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign rd  = instr_q[11:7];
  assign f3  = instr_q[14:12];
  assign unused_instr_bits = ^{instr_q[31], instr_q[29:25]};

  // Register file reads with x0 hardwired to zero
  assign rs1_val    = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val    = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : rf_q[dbg_addr_i];

  assign wb_we = (state_q == WB) && legal_q && (rd != 5'd0);

  // Decode the held instruction onto the ALU bus during EXEC only; zero otherwise
  always_comb begin
    opcode_o        = '0;
    func3_o         = '0;
    func7_5_o       = 1'b0;
    alu_operand_1_o = '0;
    alu_operand_2_o = '0;
    dec_legal       = 1'b0;
    if (state_q == EXEC) begin
      case (instr_q[6:0])
        OP_R: begin
          dec_legal       = 1'b1;
          opcode_o        = OP_R;
          func3_o         = f3;
          func7_5_o       = instr_q[30];
          alu_operand_1_o = rs1_val;
          alu_operand_2_o = rs2_val;
        end
`ifdef ALU_ISSUE_IMM_EN
        OP_I: begin
          // The ALU only understands R-type, so immediates are presented as op2
          dec_legal       = 1'b1;
          opcode_o        = OP_R;
          func3_o         = f3;
          alu_operand_1_o = rs1_val;
          if (f3 == 3'b001 || f3 == 3'b101) begin
            alu_operand_2_o = DW'(instr_q[24:20]);
            func7_5_o       = (f3 == 3'b101) ? instr_q[30] : 1'b0;
          end else begin
            alu_operand_2_o = DW'($signed(instr_q[31:20]));
            func7_5_o       = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Next-state and registered-output logic for IDLE -> EXEC -> WB
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    result_d  = result_q;
    legal_d   = legal_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    rd_we_d   = 1'b0;
    rd_addr_d = '0;
    rd_data_d = '0;
    case (state_q)
      IDLE: begin
        if (instr_valid_i && ready_q) begin
          instr_d = instr_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result_i;
        legal_d  = dec_legal;
        state_d  = WB;
      end
      WB: begin
        done_d    = 1'b1;
        illegal_d = ~legal_q;
        rd_we_d   = wb_we;
        rd_addr_d = wb_we ? rd : 5'd0;
        rd_data_d = wb_we ? result_q : '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, output and register-file flops; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      result_q  <= '0;
      legal_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      result_q  <= result_d;
      legal_q   <= legal_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      if (wb_we) rf_q[rd] <= result_q;
    end
  end

  assign instr_ready_o = ready_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign rd_we_o       = rd_we_q;
  assign rd_addr_o     = rd_addr_q;
  assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed testbench for alu_issue_unit with a reference RV32 R-type ALU model.
`timescale 1ns/1ps
module tb_alu_issue_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid_i = 1'b0;
  logic          instr_ready_o;
  logic [31:0]   instr_i = '0;
  logic [6:0]    opcode_o;
  logic [2:0]    func3_o;
  logic          func7_5_o;
  logic [DW-1:0] alu_operand_1_o, alu_operand_2_o, alu_result_i;
  logic          rd_we_o;
  logic [4:0]    rd_addr_o;
  logic [DW-1:0] rd_data_o;
  logic          done_o, illegal_o;
  logic [4:0]    dbg_addr_i = '0;
  logic [DW-1:0] dbg_data_o;

  logic          force_en = 1'b0;
  logic [31:0]   force_val = '0;

  int errors = 0;
  int checks = 0;

  logic [6:0]  cap_op;
  logic [2:0]  cap_f3;
  logic        cap_f75, cap_wb_done, cap_done, cap_ill, cap_we;
  logic [31:0] cap_op1, cap_op2, cap_data, cap_dbg_old, cap_dbg_new;
  logic [4:0]  cap_addr;

  alu_issue_unit #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .opcode_o(opcode_o), .func3_o(func3_o), .func7_5_o(func7_5_o),
    .alu_operand_1_o(alu_operand_1_o), .alu_operand_2_o(alu_operand_2_o),
    .alu_result_i(alu_result_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .done_o(done_o), .illegal_o(illegal_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f75, input logic [31:0] a, b);
    if (op != 7'd51) return 32'd0;
    case (f3)
      3'd0: return f75 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f75 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_result_i = force_en ? force_val
                      : alu_ref(opcode_o, func3_o, func7_5_o, alu_operand_1_o, alu_operand_2_o);

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'd51};
  endfunction

  // Issue one instruction and capture EXEC, WB and retire-cycle observations
  task automatic run(input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while (!instr_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=%b exp=1", instr_ready_o);
    end
    instr_i = ins; instr_valid_i = 1'b1; dbg_addr_i = ins[11:7];
    @(posedge clk);
    #1 instr_valid_i = 1'b0; instr_i = '1;
    @(negedge clk);
    cap_op = opcode_o; cap_f3 = func3_o; cap_f75 = func7_5_o;
    cap_op1 = alu_operand_1_o; cap_op2 = alu_operand_2_o;
    @(negedge clk);
    cap_wb_done = done_o; cap_dbg_old = dbg_data_o;
    @(negedge clk);
    cap_done = done_o; cap_ill = illegal_o; cap_we = rd_we_o;
    cap_addr = rd_addr_o; cap_data = rd_data_o; cap_dbg_new = dbg_data_o;
  endtask

  // Write a register by overriding the ALU result of "add rd,x0,x0"
  task automatic preload(input logic [4:0] r, input logic [31:0] v);
    force_en = 1'b1; force_val = v;
    run(rtype(7'd0, 5'd0, 5'd0, 3'd0, r));
    force_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", instr_ready_o); end
    checks++; if ({done_o, illegal_o, rd_we_o} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {done_o, illegal_o, rd_we_o}); end
    checks++; if ({opcode_o, func3_o, func7_5_o} !== 11'd0) begin errors++; $display("FAIL rst_alu_ctl got=%h exp=0", {opcode_o, func3_o, func7_5_o}); end
    checks++; if ({alu_operand_1_o, alu_operand_2_o} !== 64'd0) begin errors++; $display("FAIL rst_operands got=%h exp=0", {alu_operand_1_o, alu_operand_2_o}); end
    checks++; if ({rd_addr_o, rd_data_o} !== 37'd0) begin errors++; $display("FAIL rst_rd got=%h exp=0", {rd_addr_o, rd_data_o}); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr_i = 5'(i);
      #1;
      checks++; if (dbg_data_o !== 32'd0) begin errors++; $display("FAIL rst_rf[%0d] got=%h exp=0", i, dbg_data_o); end
    end
  endtask

  task automatic test_rtype();
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    run(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
    checks++; if ({cap_op, cap_f3, cap_f75} !== {7'd51, 3'd0, 1'b0}) begin errors++; $display("FAIL add_ctl got=%h exp=%h", {cap_op, cap_f3, cap_f75}, {7'd51, 3'd0, 1'b0}); end
    checks++; if ({cap_op1, cap_op2} !== {32'd5, 32'd3}) begin errors++; $display("FAIL add_operands got=%h exp=%h", {cap_op1, cap_op2}, {32'd5, 32'd3}); end
    checks++; if (cap_wb_done !== 1'b0) begin errors++; $display("FAIL add_early_done got=%b exp=0", cap_wb_done); end
    checks++; if ({cap_done, cap_ill, cap_we} !== 3'b101) begin errors++; $display("FAIL add_pulses got=%b exp=101", {cap_done, cap_ill, cap_we}); end
    checks++; if (cap_addr !== 5'd3) begin errors++; $display("FAIL add_rd_addr got=%0d exp=3", cap_addr); end
    checks++; if (cap_data !== 32'd8) begin errors++; $display("FAIL add_rd_data got=%h exp=8", cap_data); end
    checks++; if (cap_dbg_old !== 32'd0) begin errors++; $display("FAIL add_dbg_old got=%h exp=0", cap_dbg_old); end
    checks++; if (cap_dbg_new !== 32'd8) begin errors++; $display("FAIL add_dbg_new got=%h exp=8", cap_dbg_new); end
    run(rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    checks++; if (cap_f75 !== 1'b1) begin errors++; $display("FAIL sub_f75 got=%b exp=1", cap_f75); end
    checks++; if (cap_data !== 32'd2) begin errors++; $display("FAIL sub_data got=%h exp=2", cap_data); end
    preload(5'd1, 32'h8000_0000);
    preload(5'd2, 32'd4);
    run(rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd5));
    checks++; if ({cap_f3, cap_f75} !== 4'b1011) begin errors++; $display("FAIL sra_ctl got=%b exp=1011", {cap_f3, cap_f75}); end
    checks++; if (cap_data !== 32'hF800_0000) begin errors++; $display("FAIL sra_data got=%h exp=f8000000", cap_data); end
    dbg_addr_i = 5'd4; #1;
    checks++; if (dbg_data_o !== 32'd2) begin errors++; $display("FAIL sub_x4_kept got=%h exp=2", dbg_data_o); end
  endtask

  task automatic test_x0_illegal();
    run(rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd0));
    checks++; if ({cap_done, cap_ill, cap_we} !== 3'b100) begin errors++; $display("FAIL x0_pulses got=%b exp=100", {cap_done, cap_ill, cap_we}); end
    checks++; if ({cap_addr, cap_data} !== 37'd0) begin errors++; $display("FAIL x0_rd got=%h exp=0", {cap_addr, cap_data}); end
    checks++; if (cap_dbg_new !== 32'd0) begin errors++; $display("FAIL x0_value got=%h exp=0", cap_dbg_new); end
    run({12'h004, 5'd1, 3'd2, 5'd9, 7'h03});
    checks++; if ({cap_done, cap_ill, cap_we} !== 3'b110) begin errors++; $display("FAIL ill_pulses got=%b exp=110", {cap_done, cap_ill, cap_we}); end
    checks++; if ({cap_op, cap_f3, cap_f75, cap_op1, cap_op2} !== 75'd0) begin errors++; $display("FAIL ill_alu_bus got=%h exp=0", {cap_op, cap_f3, cap_f75, cap_op1, cap_op2}); end
    checks++; if (cap_dbg_new !== 32'd0) begin errors++; $display("FAIL ill_x9 got=%h exp=0", cap_dbg_new); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] wr[$];
    int exp_acc[3] = '{0, 3, 6};
    logic [31:0] exp_wr[3] = '{32'd10, 32'd20, 32'd40};
    preload(5'd1, 32'd5);
    @(negedge clk);
    instr_i = rtype(7'd0, 5'd1, 5'd1, 3'd0, 5'd1);
    instr_valid_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 9) instr_valid_i = 1'b0;
      if (instr_valid_i && instr_ready_o) acc.push_back(c);
      if (rd_we_o) wr.push_back(rd_data_o);
      @(negedge clk);
    end
    checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= acc.size() || acc[i] != exp_acc[i]) begin errors++; $display("FAIL b2b_accept_cycle[%0d] got=%0d exp=%0d", i, (i < acc.size()) ? acc[i] : -1, exp_acc[i]); end
      checks++;
      if (i >= wr.size() || wr[i] !== exp_wr[i]) begin errors++; $display("FAIL b2b_chain[%0d] got=%h exp=%h", i, (i < wr.size()) ? wr[i] : 32'hx, exp_wr[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    preload(5'd3, 32'd7);
    @(negedge clk);
    instr_i = rtype(7'd0, 5'd3, 5'd1, 3'd0, 5'd3); instr_valid_i = 1'b1;
    @(posedge clk);
    #1 instr_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (opcode_o !== 7'd51) begin errors++; $display("FAIL mid_in_exec got=%0d exp=51", opcode_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL mid_idle got=%b exp=1", instr_ready_o); end
    checks++; if (opcode_o !== 7'd0) begin errors++; $display("FAIL mid_alu_idle got=%0d exp=0", opcode_o); end
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done_o || rd_we_o) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_retire got=%b exp=0", seen); end
    dbg_addr_i = 5'd3; #1;
    checks++; if (dbg_data_o !== 32'd0) begin errors++; $display("FAIL mid_x3_cleared got=%h exp=0", dbg_data_o); end
    dbg_addr_i = 5'd1; #1;
    checks++; if (dbg_data_o !== 32'd0) begin errors++; $display("FAIL mid_x1_cleared got=%h exp=0", dbg_data_o); end
  endtask

  task automatic test_imm();
    run({12'hFFF, 5'd0, 3'd0, 5'd6, 7'd19});
`ifdef ALU_ISSUE_IMM_EN
    checks++; if ({cap_op, cap_f3, cap_f75} !== {7'd51, 3'd0, 1'b0}) begin errors++; $display("FAIL addi_ctl got=%h exp=%h", {cap_op, cap_f3, cap_f75}, {7'd51, 3'd0, 1'b0}); end
    checks++; if (cap_op2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", cap_op2); end
    checks++; if ({cap_ill, cap_we, cap_data} !== {2'b01, 32'hFFFF_FFFF}) begin errors++; $display("FAIL addi_wb got=%h exp=%h", {cap_ill, cap_we, cap_data}, {2'b01, 32'hFFFF_FFFF}); end
    run({7'h20, 5'd4, 5'd6, 3'd5, 5'd7, 7'd19});
    checks++; if ({cap_op, cap_f3, cap_f75} !== {7'd51, 3'd5, 1'b1}) begin errors++; $display("FAIL srai_ctl got=%h exp=%h", {cap_op, cap_f3, cap_f75}, {7'd51, 3'd5, 1'b1}); end
    checks++; if ({cap_op1, cap_op2} !== {32'hFFFF_FFFF, 32'd4}) begin errors++; $display("FAIL srai_operands got=%h exp=%h", {cap_op1, cap_op2}, {32'hFFFF_FFFF, 32'd4}); end
    checks++; if (cap_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL srai_data got=%h exp=ffffffff", cap_data); end
`else
    checks++; if ({cap_done, cap_ill, cap_we} !== 3'b110) begin errors++; $display("FAIL addi_illegal got=%b exp=110", {cap_done, cap_ill, cap_we}); end
    checks++; if (cap_dbg_new !== 32'd0) begin errors++; $display("FAIL addi_x6 got=%h exp=0", cap_dbg_new); end
    checks++; if (cap_op !== 7'd0) begin errors++; $display("FAIL addi_opcode got=%0d exp=0", cap_op); end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_x0_illegal();
    test_back_to_back();
    test_reset_mid();
    test_imm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
